// File: rtl/uart_boot_loader.sv
// uart_boot_loader: assembles a framed firmware image from UART bytes into RAM words, then releases the CPU.
module uart_boot_loader #(
   parameter int         ADDR_WIDTH     = 14,
   parameter int         MAX_WORDS      = 16384,
   parameter int         TIMEOUT_CYCLES = 480000,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter logic [7:0] ACK_BYTE       = 8'h06,
   parameter logic [7:0] NAK_BYTE       = 8'h15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid_i,
   input  logic [7:0]            rx_data_i,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic [3:0]            ram_wmask_o,
   output logic                  cpu_reset_n_o,
   output logic                  boot_done_o,
   output logic                  boot_error_o,
   output logic                  busy_o
);
   localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, DATA = 3'd3,
                          CSUM = 3'd4, ACK = 3'd5, NAK = 3'd6, DONE = 3'd7;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0] MAXW = 17'(MAX_WORDS);
   logic [2:0]            state_q, state_d;
   logic [15:0]           len_q;
   logic [7:0]            csum_q;
   logic [1:0]            bidx_q;
   logic [ADDR_WIDTH-1:0] widx_q, ram_addr_q;
   logic [31:0]           word_q, ram_wdata_q;
   logic [TW-1:0]         tmo_q;
   logic                  ram_we_q, boot_error_q;
   logic                  counting, timeout, acc, sync, in_data, wr, last_word;
   logic [15:0]           n_rx;
   logic [31:0]           word_d;
   assign counting  = state_q == LEN_LO || state_q == LEN_HI || state_q == DATA || state_q == CSUM;
   assign timeout   = counting && tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign acc       = rx_valid_i && !timeout;
   assign sync      = state_q == IDLE && rx_valid_i && rx_data_i == SYNC_BYTE;
   assign in_data   = state_q == DATA && acc;
   assign wr        = in_data && bidx_q == 2'd3;
   assign last_word = 32'(widx_q) == 32'(len_q) - 32'd1;
   assign n_rx      = {rx_data_i, len_q[7:0]};
   // Bytes arrive LSB first, so shifting right leaves byte 0 in bits [7:0] after four bytes.
   assign word_d    = {rx_data_i, word_q[31:8]};
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = sync ? LEN_LO : IDLE;
         LEN_LO:  state_d = rx_valid_i ? LEN_HI : LEN_LO;
         LEN_HI:  state_d = !rx_valid_i ? LEN_HI : {1'b0, n_rx} > MAXW ? NAK : n_rx == 16'd0 ? CSUM : DATA;
         DATA:    state_d = wr && last_word ? CSUM : DATA;
         CSUM:    state_d = !rx_valid_i ? CSUM : rx_data_i == csum_q ? ACK : NAK;
         ACK:     state_d = tx_ready_i ? DONE : ACK;
         NAK:     state_d = tx_ready_i ? IDLE : NAK;
         default: state_d = DONE;
      endcase
      if (timeout) state_d = NAK;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         csum_q       <= '0;
         bidx_q       <= '0;
         widx_q       <= '0;
         word_q       <= '0;
         tmo_q        <= '0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         boot_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q[7:0]   <= state_q == LEN_LO && acc ? rx_data_i : len_q[7:0];
         len_q[15:8]  <= state_q == LEN_HI && acc ? rx_data_i : len_q[15:8];
         csum_q       <= sync ? 8'd0 : in_data ? csum_q + rx_data_i : csum_q;
         bidx_q       <= sync ? 2'd0 : in_data ? bidx_q + 2'd1 : bidx_q;
         widx_q       <= sync ? '0 : wr ? widx_q + ADDR_WIDTH'(1) : widx_q;
         word_q       <= in_data ? word_d : word_q;
         tmo_q        <= rx_valid_i || !counting ? '0 : tmo_q + TW'(1);
         ram_we_q     <= wr;
         ram_addr_q   <= wr ? widx_q : ram_addr_q;
         ram_wdata_q  <= wr ? word_d : ram_wdata_q;
         boot_error_q <= sync ? 1'b0 : state_d == NAK ? 1'b1 : boot_error_q;
      end
   end
   assign tx_valid_o    = state_q == ACK || state_q == NAK;
   assign tx_data_o     = state_q == ACK ? ACK_BYTE : state_q == NAK ? NAK_BYTE : 8'h00;
   assign ram_we_o      = ram_we_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_wdata_o   = ram_wdata_q;
   assign ram_wmask_o   = ram_we_q ? 4'hF : 4'h0;
   assign cpu_reset_n_o = state_q == DONE;
   assign boot_done_o   = state_q == DONE;
   assign boot_error_o  = boot_error_q;
   assign busy_o        = state_q != IDLE && state_q != DONE;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench for uart_boot_loader with a short timeout.
module tb_uart_boot_loader;
   logic        clk = 1'b0, reset = 1'b1;
   logic        rx_valid = 1'b0, tx_ready = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic [7:0]  tx_data;
   logic        tx_valid, ram_we, cpu_reset_n, boot_done, boot_error, busy;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_wmask;
   int          pass = 0, total = 0;
   logic [13:0] wa[$];
   logic [31:0] wd[$];
   logic [7:0]  txq[$];
   logic [31:0] words[$];
   uart_boot_loader #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
      .cpu_reset_n_o(cpu_reset_n), .boot_done_o(boot_done), .boot_error_o(boot_error), .busy_o(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   always @(negedge clk) begin
      if (!reset) begin
         if (ram_we) begin
            if (wa.size() == 0) chk("unexpected_write", 64'(ram_addr), 64'h3fff_dead);
            else begin
               chk("we_addr", 64'(ram_addr), 64'(wa.pop_front()));
               chk("we_data", 64'(ram_wdata), 64'(wd.pop_front()));
               chk("we_mask", 64'(ram_wmask), 64'hF);
            end
         end
         if (tx_valid && tx_ready) begin
            if (txq.size() == 0) chk("unexpected_tx", 64'(tx_data), 64'h1ff);
            else chk("tx_byte", 64'(tx_data), 64'(txq.pop_front()));
         end
      end
   end
   task automatic send(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask
   task automatic frame(input int gap, input bit bad);
      logic [7:0] cs;
      logic [7:0] b;
      int n;
      cs = 8'h00;
      n = words.size();
      send(8'hA5, gap);
      send(8'(n), gap);
      send(8'(n >> 8), gap);
      for (int i = 0; i < n; i++) begin
         wa.push_back(14'(i));
         wd.push_back(words[i]);
         for (int k = 0; k < 4; k++) begin
            b = 8'(words[i] >> (8 * k));
            cs = cs + b;
            send(b, gap);
         end
      end
      txq.push_back(bad ? 8'h15 : 8'h06);
      send(bad ? 8'h00 : cs, 0);
   endtask
   task automatic wait_tx();
      int n;
      n = 0;
      while (txq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      chk("tx_drained", 64'(txq.size()), 64'd0);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      wa.delete(); wd.delete(); txq.delete();
      chk("rst_outs", {tx_data, tx_valid, ram_we, ram_wmask, cpu_reset_n, boot_done, boot_error, busy}, 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_wdata", 64'(ram_wdata), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask
   initial begin
      int n;
      do_reset();
      words = '{32'h12345678, 32'hDEADBEEF};
      frame(2, 1'b1);
      wait_tx();
      chk("nak_state", {boot_error, cpu_reset_n, boot_done, busy}, 64'b1000);
      send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
      frame(0, 1'b0);
      wait_tx();
      chk("ack_state", {boot_error, cpu_reset_n, boot_done, busy}, 64'b0110);
      words = '{32'h04030201};
      send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h0A, 3);
      chk("done_sticky", {cpu_reset_n, boot_done, busy, tx_valid}, 64'b1100);
      do_reset();
      send(8'h00, 1); send(8'hFF, 1); send(8'h5A, 1);
      tx_ready = 1'b0;
      frame(1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("ack_hold", {tx_valid, tx_data, boot_done, cpu_reset_n}, {1'b1, 8'h06, 2'b00});
         @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      wait_tx();
      chk("ack_hold_done", {tx_valid, boot_done, cpu_reset_n}, 64'b011);
      do_reset();
      send(8'hA5, 1); send(8'h01, 1); send(8'h00, 1); send(8'h11, 1);
      txq.push_back(8'h15);
      send(8'h22, 0);
      n = 0;
      while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("timeout_cycles", 64'(n), 64'd16);
      @(posedge clk); #1;
      chk("timeout_state", {boot_error, busy, boot_done, tx_valid}, 64'b1000);
      chk("timeout_tx", 64'(txq.size()), 64'd0);
      do_reset();
      send(8'hA5, 1); send(8'h01, 1);
      txq.push_back(8'h15);
      send(8'h40, 0);
      wait_tx();
      chk("too_long", {boot_error, busy, boot_done}, 64'b100);
      send(8'hA5, 1); send(8'h00, 1); send(8'h00, 1);
      txq.push_back(8'h06);
      send(8'h00, 0);
      wait_tx();
      chk("zero_len", {boot_error, boot_done, cpu_reset_n}, 64'b011);
      do_reset();
      send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
      do_reset();
      repeat (8) @(posedge clk);
      #1;
      chk("mid_reset_idle", {busy, ram_we, tx_valid, boot_done}, 64'd0);
      chk("writes_left", 64'(wa.size()), 64'd0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
